// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - binary to BCD converter with time-multiplexed digit scan
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits with code 4'hF)
`timescale 1ns/1ps
module bcd_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  value_valid,
  input  logic [BIN_WIDTH-1:0]  value,
  output logic                  value_ready,
  output logic [3:0]            digit,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  overflow
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP_W = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0]          MAX_VAL = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [BIN_WIDTH-1:0] MAX_OP  = MAX_VAL[BIN_WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] op_q;
  logic [BCD_W-1:0]     work_q;
  logic [BCD_W-1:0]     disp_q;
  logic [STEP_W-1:0]    steps_q;
  logic                 ovf_work_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;

  logic [63:0]          value_ext;
  logic                 sat;
  logic [BIN_WIDTH-1:0] operand;
  logic [BCD_W-1:0]     adj;
  logic [BCD_W-1:0]     next_disp;
  logic [IDX_W-1:0]     next_idx;
  logic                 terminal;
  logic [3:0]           next_digit;

  // Values beyond what the display can show are clamped to all nines
  always_comb begin
    value_ext = 64'(value);
    sat       = value_ext > MAX_VAL;
    operand   = sat ? MAX_OP : value;
  end

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  always_comb begin
    adj = work_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  // Next display contents and scan position, so the new index sees a freshly latched value
  always_comb begin
    next_disp = (state == DONE) ? work_q : disp_q;
    terminal  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    next_idx  = idx_q;
    if (terminal) begin
      next_idx = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Select the nibble to present, optionally replacing leading zeros with the blank code
  always_comb begin
    logic [NUM_DIGITS-1:0] blank;
    logic                  all_zero;
    blank      = '0;
    all_zero   = 1'b1;
    next_digit = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (next_disp[4*i +: 4] == 4'd0);
      blank[i] = all_zero;
    end
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == next_idx) next_digit = blank[i] ? 4'hF : next_disp[4*i +: 4];
    end
  end

  // Handshake and conversion sequencer; display and overflow commit together in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      work_q      <= '0;
      disp_q      <= '0;
      steps_q     <= '0;
      ovf_work_q  <= 1'b0;
      overflow    <= 1'b0;
      value_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (value_valid && value_ready) begin
            op_q        <= operand;
            ovf_work_q  <= sat;
            work_q      <= '0;
            steps_q     <= STEP_W'(BIN_WIDTH);
            value_ready <= 1'b0;
            state       <= CONVERT;
          end
        end
        CONVERT: begin
          work_q  <= {adj[BCD_W-2:0], op_q[BIN_WIDTH-1]};
          op_q    <= op_q << 1;
          steps_q <= steps_q - STEP_W'(1);
          if (steps_q == STEP_W'(1)) state <= DONE;
        end
        DONE: begin
          disp_q      <= work_q;
          overflow    <= ovf_work_q;
          value_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          value_ready <= 1'b1;
        end
      endcase
    end
  end

  // Free-running refresh divider and scan index with registered digit outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      digit     <= 4'd0;
      digit_sel <= NUM_DIGITS'(1);
    end else begin
      cnt_q     <= terminal ? '0 : cnt_q + CNT_W'(1);
      idx_q     <= next_idx;
      digit     <= next_digit;
      digit_sel <= NUM_DIGITS'(1) << next_idx;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - scoreboard bench for bcd_display_scanner
`timescale 1ns/1ps
module tb_bcd_display_scanner;

  localparam int ND  = 4;
  localparam int BW  = 14;
  localparam int RD  = 4;
  localparam int LAT = BW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          value_valid = 1'b0;
  logic [BW-1:0] value = '0;
  logic          value_ready;
  logic [3:0]    digit;
  logic [ND-1:0] digit_sel;
  logic          overflow;

  bcd_display_scanner #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .value_valid(value_valid), .value(value),
    .value_ready(value_ready), .digit(digit), .digit_sel(digit_sel), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {int val; int ovf; int e0;} item_t;
  item_t sb[$];

  int errors = 0;
  int checks = 0;
  int edges;
  int disp_val = 0;
  int disp_ovf = 0;

  // Posedges seen since reset release; the scan position follows from it arithmetically
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_nib(input int v, input int i);
    int p = 1;
    int n;
    for (int k = 0; k < i; k++) p = p * 10;
    n = (v / p) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && v < p) n = 15;
`endif
    return n;
  endfunction

  // Monitor: a rising value_ready means a result was committed; pop and check it, then check the scan
  initial begin
    int prev_ready = 1;
    int idx;
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ready = 1;
      end else begin
        if (value_ready && prev_ready == 0) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            it = sb.pop_front();
            chk("latency", edges - it.e0, LAT);
            disp_val = it.val;
            disp_ovf = it.ovf;
          end
        end
        prev_ready = int'(value_ready);
        idx = (edges / RD) % ND;
        chk("digit_sel", int'(digit_sel), 1 << idx);
        chk("digit", int'(digit), exp_nib(disp_val, idx));
        chk("overflow", int'(overflow), disp_ovf);
      end
    end
  end

  task automatic send(input int v);
    int shown;
    value_valid = 1'b1;
    value = BW'(v);
    for (int t = 0; t < 100; t++) begin
      if (value_ready) begin
        shown = (v > 9999) ? 9999 : v;
        sb.push_back('{val: shown, ovf: (v > 9999) ? 1 : 0, e0: edges + 1});
        @(posedge clk);
        @(negedge clk);
        value_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", 0, 1);
    value_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", int'(value_ready), 1);
    chk("rst_digit", int'(digit), 0);
    chk("rst_sel", int'(digit_sel), 1);
    chk("rst_overflow", int'(overflow), 0);
    sb.delete();
    disp_val = 0;
    disp_ovf = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v;
    @(negedge clk);
    @(negedge clk);
    chk("init_ready", int'(value_ready), 1);
    chk("init_digit", int'(digit), 0);
    chk("init_sel", int'(digit_sel), 1);
    chk("init_overflow", int'(overflow), 0);
    #2 rst_n = 1'b1;
    repeat (22) @(negedge clk);
    do_reset();
    @(negedge clk);

    send(1234);
    repeat (40) @(negedge clk);
    send(16383);
    repeat (40) @(negedge clk);
    send(5);
    repeat (40) @(negedge clk);
    send(7);
    send(42);
    repeat (40) @(negedge clk);
    send(0);
    repeat (40) @(negedge clk);
    send(10000);
    repeat (40) @(negedge clk);

    send(9876);
    repeat (5) @(negedge clk);
    do_reset();
    @(negedge clk);
    send(9876);
    repeat (40) @(negedge clk);

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10000, 16383));
      else                           v = int'($urandom_range(0, 9999));
      send(v);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    chk("pending_results", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
